// File: rtl/log2_seq_pkg.sv
// Shared types and default sizing for the floor(log2) request sequencer.
package log2_seq_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/log2_req_sequencer.sv
// Feeds buffered N values to the floor(log2) core one at a time and returns {N, R}
// on a valid/ready stream, with a watchdog so a silent core cannot stall the pipe.
module log2_req_sequencer import log2_seq_pkg::*; #(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_N,
  output logic [DATA_W-1:0]        out_R,
  output logic                     out_zero,
  output logic                     out_err,
  input  logic                     out_ready,
  output logic                     core_start,
  output logic [DATA_W-1:0]        core_N,
  input  logic                     core_done,
  input  logic [DATA_W-1:0]        core_R,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  seq_state_t        state_q, state_d;
  logic [DATA_W-1:0] cur_n_q, cur_n_d;
  logic [DATA_W-1:0] res_n_q, res_n_d;
  logic [DATA_W-1:0] res_r_q, res_r_d;
  logic              res_zero_q, res_zero_d;
  logic              res_err_q, res_err_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  assign fifo_push = in_valid && !fifo_full;
  assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty;

  sync_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    cur_n_d    = cur_n_q;
    res_n_d    = res_n_q;
    res_r_d    = res_r_q;
    res_zero_d = res_zero_q;
    res_err_d  = res_err_q;
    timer_d    = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          cur_n_d = fifo_dout;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (timer_q != TMR_LAST) timer_d = timer_q + TMR_W'(1);
        if (core_done) begin
          res_n_d    = cur_n_q;
          res_r_d    = core_R;
          res_zero_d = (cur_n_q == '0);
          res_err_d  = 1'b0;
          state_d    = S_OUT;
        end else if (timer_q == TMR_LAST) begin
          res_n_d    = cur_n_q;
          res_r_d    = '0;
          res_zero_d = (cur_n_q == '0);
          res_err_d  = 1'b1;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cur_n_q    <= '0;
      res_n_q    <= '0;
      res_r_q    <= '0;
      res_zero_q <= 1'b0;
      res_err_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_n_q    <= cur_n_d;
      res_n_q    <= res_n_d;
      res_r_q    <= res_r_d;
      res_zero_q <= res_zero_d;
      res_err_q  <= res_err_d;
      timer_q    <= timer_d;
    end
  end

  assign in_ready   = !fifo_full;
  assign out_valid  = (state_q == S_OUT);
  assign out_N      = res_n_q;
  assign out_R      = res_r_q;
  assign out_zero   = res_zero_q;
  assign out_err    = res_err_q;
  assign core_start = (state_q == S_ISSUE);
  assign core_N     = cur_n_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_log2_req_sequencer.sv
// Bench for log2_req_sequencer: behavioural core stub, scoreboard and directed/random tests.
module tb_log2_req_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_N, out_R;
  logic       out_zero, out_err;
  logic       out_ready = 1'b0;
  logic       core_start;
  logic [7:0] core_N;
  logic       core_done;
  logic [7:0] core_R;
  logic       busy;
  logic [2:0] fifo_count;

  log2_req_sequencer #(
    .DATA_W  (8),
    .DEPTH   (4),
    .TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_N      (out_N),
    .out_R      (out_R),
    .out_zero   (out_zero),
    .out_err    (out_err),
    .out_ready  (out_ready),
    .core_start (core_start),
    .core_N     (core_N),
    .core_done  (core_done),
    .core_R     (core_R),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference floor(log2 n), 0 for n = 0 or 1.
  function automatic int flog2(input logic [7:0] n);
    int r = 0;
    for (int i = 0; i < 8; i++) if (n[i]) r = i;
    return r;
  endfunction

  // Core stub: start seen in cycle t gives a one-cycle done in cycle t+k+2.
  logic       stub_done = 1'b0;
  logic [7:0] stub_r = '0;
  logic       spur_done = 1'b0;
  logic [7:0] spur_r = '0;
  bit         stub_dead = 1'b0;
  assign core_done = stub_done | spur_done;
  assign core_R    = spur_done ? spur_r : stub_r;

  initial begin : core_stub
    int rem;
    rem = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rem = 0;
        stub_done = 1'b0;
      end else if (core_start) begin
        rem = flog2(core_N) + 2;
        stub_r = 8'(flog2(core_N));
        stub_done = 1'b0;
      end else if (rem > 0) begin
        rem--;
        stub_done = (rem == 0) && !stub_dead;
      end else begin
        stub_done = 1'b0;
      end
    end
  end

  // Scoreboard: every accepted N must come back once, in order, with its expected result.
  typedef struct {
    logic [7:0] n;
    logic [7:0] r;
    logic       zero;
    logic       err;
  } res_t;
  res_t exp_q[$];

  initial begin : monitor
    res_t e;
    res_t a;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_out++;
          check("sb_has_entry", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_N", out_N, e.n);
            check("sb_R", out_R, e.r);
            check("sb_zero", out_zero, e.zero);
            check("sb_err", out_err, e.err);
          end
        end
        if (in_valid && in_ready) begin
          a.n    = in_data;
          a.r    = stub_dead ? 8'd0 : 8'(flog2(in_data));
          a.zero = (in_data == 8'd0);
          a.err  = stub_dead;
          exp_q.push_back(a);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] n);
    int  c;
    logic was;
    c = 0;
    was = 1'b0;
    in_valid = 1'b1;
    in_data  = n;
    while (!was && c < 200) begin
      was = in_ready;
      step();
      c++;
    end
    in_valid = 1'b0;
    check("push_accept", was, 1);
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && c < budget) begin
      step();
      c++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // One request from an idle, empty sequencer; checks pulse, latency and result.
  task automatic run_one(input logic [7:0] n, input logic [7:0] r, input logic zero,
                         input logic err, input int lat);
    int c;
    int l;
    out_ready = 1'b0;
    push_one(n);
    c = 0;
    while (!core_start && c < 20) begin
      step();
      c++;
    end
    check("start_seen", core_start, 1);
    check("core_N", core_N, n);
    step();
    l = 1;
    check("start_pulse_1cyc", core_start, 0);
    while (!out_valid && l < 40) begin
      step();
      l++;
    end
    check("latency", l, lat);
    check("out_N", out_N, n);
    check("out_R", out_R, r);
    check("out_zero", out_zero, zero);
    check("out_err", out_err, err);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
  endtask

  typedef struct {
    logic [7:0] n;
    logic [7:0] r;
    logic       zero;
    int         lat;
  } vec_t;
  vec_t vecs[9];

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int n0;
    vecs[0] = '{8'd200, 8'd7, 1'b0, 10};
    vecs[1] = '{8'd0,   8'd0, 1'b1, 3};
    vecs[2] = '{8'd1,   8'd0, 1'b0, 3};
    vecs[3] = '{8'd2,   8'd1, 1'b0, 4};
    vecs[4] = '{8'd3,   8'd1, 1'b0, 4};
    vecs[5] = '{8'd16,  8'd4, 1'b0, 7};
    vecs[6] = '{8'd64,  8'd6, 1'b0, 9};
    vecs[7] = '{8'd128, 8'd7, 1'b0, 10};
    vecs[8] = '{8'd255, 8'd7, 1'b0, 10};

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_core_start", core_start, 0);
    check("rst_out_R", out_R, 0);
    check("rst_out_N", out_N, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_err", out_err, 0);

    // Table: single requests, including N=0 then N=1 back to back.
    for (int i = 0; i < 9; i++)
      run_one(vecs[i].n, vecs[i].r, vecs[i].zero, 1'b0, vecs[i].lat);

    // Backpressure: one in flight, four buffered, sixth refused until space frees up.
    n0 = n_out;
    out_ready = 1'b0;
    push_one(8'd3);
    push_one(8'd5);
    push_one(8'd9);
    push_one(8'd17);
    push_one(8'd33);
    check("bp_count_full", fifo_count, 4);
    in_valid = 1'b1;
    in_data  = 8'd65;
    check("bp_in_ready_low", in_ready, 0);
    step();
    step();
    check("bp_count_held", fifo_count, 4);
    out_ready = 1'b1;
    push_one(8'd65);
    drain(500);
    check("bp_result_count", n_out - n0, 6);
    out_ready = 1'b0;

    // Silent core: watchdog fires, spurious done in OUT and IDLE is ignored.
    stub_dead = 1'b1;
    run_one(8'd8, 8'd0, 1'b0, 1'b1, 16);
    stub_dead = 1'b0;
    spur_r = 8'd3;
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    check("spur_idle_busy", busy, 0);
    check("spur_idle_valid", out_valid, 0);
    check("spur_idle_R", out_R, 0);
    stub_dead = 1'b1;
    out_ready = 1'b0;
    push_one(8'd8);
    for (int c = 0; c < 40 && !out_valid; c++) step();
    check("to_valid", out_valid, 1);
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    check("spur_out_R", out_R, 0);
    check("spur_out_err", out_err, 1);
    check("spur_out_valid", out_valid, 1);
    stub_dead = 1'b0;
    drain(100);
    out_ready = 1'b0;

    // Reset while the core is working and the FIFO holds entries.
    push_one(8'd128);
    for (int c = 0; c < 20 && !core_start; c++) step();
    push_one(8'd20);
    push_one(8'd30);
    check("mid_busy", busy, 1);
    check("mid_count", fifo_count, 2);
    reset = 1'b1;
    step();
    check("mr_busy", busy, 0);
    check("mr_count", fifo_count, 0);
    check("mr_valid", out_valid, 0);
    check("mr_in_ready", in_ready, 1);
    reset = 1'b0;
    step();
    run_one(8'd16, 8'd4, 1'b0, 1'b0, 7);

    // Push and pop in the same cycle with two entries buffered.
    n0 = n_out;
    out_ready = 1'b0;
    push_one(8'd2);
    push_one(8'd4);
    push_one(8'd6);
    for (int c = 0; c < 40 && !out_valid; c++) step();
    check("pp_valid", out_valid, 1);
    check("pp_count_before", fifo_count, 2);
    out_ready = 1'b1;
    step();
    check("pp_idle", busy, 0);
    in_valid = 1'b1;
    in_data  = 8'd8;
    check("pp_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("pp_count_after", fifo_count, 2);
    drain(200);
    check("pp_result_count", n_out - n0, 4);

    // Random traffic against the scoreboard.
    n0 = n_out;
    repeat (400) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    drain(1000);
    check("rand_progress", 32'(n_out > n0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
